cam_capture_ctrl: RTL and testbench
===================================

Name: cam_capture_ctrl

Overview:
Frame-level sequencer for the camera-to-framebuffer write path, running in the pclk domain. It decides which camera frames are written to the QQVGA frame buffer by driving cap_en, the write gate for the pixel-capture FSM. It also checks each captured frame's pixel count and exposes frame status to the control logic.
Modes: stop, single snapshot, continuous, decimated.

Parameters:
NPIXELS, 19200, pixels per frame (QQVGA 160x120); expected px_wr count per frame
NLINES, 120, lines per frame (used only with CAP_LINE_CHECK_EN)
CNT_W, 8, width of frame_cnt
SKIP_W, 4, width of skip

Ports:
pclk  in  1  camera pixel clock; only clock
rst  in  1  asynchronous, active-low reset
vsync  in  1  camera vsync; high = vertical blanking
href  in  1  camera href; high = valid line data
px_wr  in  1  one-cycle pulse per pixel written by the capture FSM
mode  in  2  00 STOP, 01 SINGLE, 10 CONT, 11 DECIM
start  in  1  one-cycle pulse; arms a snapshot in SINGLE mode
abort  in  1  one-cycle pulse; cancels any activity immediately
skip  in  SKIP_W  DECIM mode: capture one frame, then drop skip frames
cap_en  out  1  write enable gate to the capture FSM
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse at end of a captured frame
frame_err  out  1  sticky error flag; cleared on the next entry to CAPTURE
frame_cnt  out  CNT_W  number of completed captured frames; wraps

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - cap_en, busy, frame_done, frame_err = 0; frame_cnt = 0.
  - vsync_q = 1; px_cnt and skip_cnt cleared.
  - Reset asserted mid-frame aborts with no frame_done.
- Edge detect: vsync_q registers vsync.
  - vs_fall = vsync_q & ~vsync.
  - vs_rise = ~vsync_q & vsync.
- States: IDLE, ARM, CAPTURE. All outputs are registered.
- IDLE:
  - Go to ARM on start in SINGLE mode.
  - Go to ARM when mode is CONT or DECIM (no start needed).
  - start in STOP or CONT is ignored.
- ARM:
  - On vs_fall: if skip_cnt==0, go to CAPTURE, set cap_en=1 and clear px_cnt and frame_err, all in the same edge. Otherwise decrement skip_cnt and stay in ARM.
  - If mode becomes STOP, go to IDLE.
  - skip_cnt loads skip when ARM is entered from CAPTURE in DECIM mode; otherwise it is 0.
- CAPTURE:
  - px_cnt increments on each px_wr while cap_en=1.
  - When px_cnt reaches NPIXELS-1 together with a px_wr, cap_en drops on the next edge (overflow guard).
  - Any px_wr after that, before vs_rise, sets frame_err.
  - On vs_rise:
    - cap_en=0; frame_done pulses for 1 cycle; frame_cnt increments modulo 2^CNT_W.
    - frame_err is set if px_cnt != NPIXELS.
    - Next state: IDLE if mode is SINGLE or STOP; ARM if CONT or DECIM.
  - A mode change during CAPTURE takes effect only at vs_rise; the current frame always completes.
- abort:
  - Has priority over every other event, including a simultaneous start or vs_rise.
  - Effect on the next edge: IDLE, cap_en=0, no frame_done, frame_cnt unchanged.
- Latency:
  - cap_en rises 1 pclk after the edge that detects vsync falling.
  - frame_done comes 1 pclk after the edge that detects vsync rising.
- A vsync already low when arming does not trigger capture; a true falling edge is required.

Optional Feature:
CAP_LINE_CHECK_EN:
- Defined:
  - A line counter increments on each href rising edge during CAPTURE.
  - At vs_rise, frame_err is also set if the line count != NLINES.
  - Extra output port line_err (1 bit, sticky, cleared on entry to CAPTURE) flags the line mismatch separately.
- Undefined: no line counter and no line_err port; only the pixel-count check applies.

Decomposition:
- Shared package cam_pkg:
  - mode encodings MODE_STOP/SINGLE/CONT/DECIM.
  - state encodings ST_IDLE/ARM/CAPTURE.
  - QQVGA constants QQVGA_W=160, QQVGA_H=120, QQVGA_NPIX=19200.
- One sub-module, sync_edge_det:
  - registers one signal with a reset value parameter.
  - outputs rise and fall pulses.
  - instantiated for vsync, and for href when CAP_LINE_CHECK_EN is defined.

Test Plan:
- SINGLE: start, then one frame of 19200 px_wr -> cap_en high for exactly that frame; frame_done pulses once; frame_cnt=1; frame_err=0; back in IDLE with busy=0.
- CONT over 3 frames with 19200 pixels each -> 3 frame_done pulses; frame_cnt=3; cap_en low during every vsync-high period.
- DECIM with skip=2 over 6 frames -> frames 1 and 4 captured; frame_cnt=2.
- Short frame of 19000 px_wr -> frame_err=1 at frame_done. Over-long frame of 19210 px_wr -> cap_en drops after pixel 19200 and frame_err=1.
- abort mid-CAPTURE, with abort and vs_rise in the same cycle -> IDLE; cap_en=0 next cycle; no frame_done; frame_cnt unchanged.
- rst pulsed low mid-frame -> all outputs 0 immediately. With CAP_LINE_CHECK_EN and 119 href lines -> line_err=1 and frame_err=1.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path: mode and state encodings
// and the QQVGA frame geometry.
package cam_pkg;

   localparam int unsigned QQVGA_W    = 160;
   localparam int unsigned QQVGA_H    = 120;
   localparam int unsigned QQVGA_NPIX = QQVGA_W * QQVGA_H;

   typedef enum logic [1:0] {
      MODE_STOP   = 2'b00,
      MODE_SINGLE = 2'b01,
      MODE_CONT   = 2'b10,
      MODE_DECIM  = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_ARM     = 2'b01,
      ST_CAPTURE = 2'b10
   } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Registers one signal and reports its rising and falling edges.
//   pclk    clock
//   rst     asynchronous active-low reset (register loads RST_VAL)
//   d       monitored signal
//   rise_c  combinational pulse: d went 0 -> 1 since last edge
//   fall_c  combinational pulse: d went 1 -> 0 since last edge
module sync_edge_det #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic pclk,
   input  logic rst,
   input  logic d,
   output logic rise_c,
   output logic fall_c
);

   logic d_q;

   // previous-cycle value of d
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) d_q <= RST_VAL;
      else      d_q <= d;
   end

   assign rise_c = ~d_q &  d;
   assign fall_c =  d_q & ~d;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Frame-level sequencer for the camera-to-framebuffer write path. Decides
// which frames are written (cap_en), checks each captured frame's pixel
// count and reports frame status.
// Optional feature macro: CAP_LINE_CHECK_EN (adds href line counting and
// the line_err port).
//   pclk        camera pixel clock
//   rst         asynchronous active-low reset
//   vsync       high = vertical blanking
//   href        high = valid line data
//   px_wr       one pulse per pixel written by the capture FSM
//   mode        STOP / SINGLE / CONT / DECIM
//   start       arms a snapshot in SINGLE mode
//   abort       cancels any activity on the next edge
//   skip        frames dropped after each capture in DECIM mode
//   cap_en      write gate to the capture FSM
//   busy        high when not IDLE
//   frame_done  one-cycle pulse at the end of a captured frame
//   frame_err   sticky frame error, cleared on entry to CAPTURE
//   frame_cnt   completed captured frames (wraps)
//   line_err    sticky line-count error (CAP_LINE_CHECK_EN only)
module cam_capture_ctrl
   import cam_pkg::*;
#(
   parameter int unsigned NPIXELS = QQVGA_NPIX,
   parameter int unsigned NLINES  = QQVGA_H,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned SKIP_W  = 4
) (
   input  logic              pclk,
   input  logic              rst,
   input  logic              vsync,
   input  logic              href,
   input  logic              px_wr,
   input  logic [1:0]        mode,
   input  logic              start,
   input  logic              abort,
   input  logic [SKIP_W-1:0] skip,
   output logic              cap_en,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_err,
   output logic [CNT_W-1:0]  frame_cnt
`ifdef CAP_LINE_CHECK_EN
   ,
   output logic              line_err
`endif
);

   localparam int unsigned PX_W = $clog2(NPIXELS + 1);

   mode_e             mode_s;
   state_e            state, state_nxt;
   logic [PX_W-1:0]   px_cnt, px_cnt_nxt, px_cnt_upd;
   logic [SKIP_W-1:0] skip_cnt, skip_cnt_nxt;
   logic [CNT_W-1:0]  frame_cnt_nxt;
   logic              cap_en_nxt, busy_nxt, frame_done_nxt, frame_err_nxt;
   logic              vs_rise, vs_fall;
   logic              px_take, px_last, px_stray;
   logic              cap_start, frame_end, line_bad;

   assign mode_s = mode_e'(mode);

   // vsync reset value 1: a vsync already low after reset is not a fall
   sync_edge_det #(.RST_VAL(1'b1)) u_vs_det (
      .pclk   (pclk),
      .rst    (rst),
      .d      (vsync),
      .rise_c (vs_rise),
      .fall_c (vs_fall)
   );

   // pixel bookkeeping; px_cnt_upd already includes this cycle's pixel
   assign px_take    = px_wr & cap_en;
   assign px_last    = px_take & (px_cnt == PX_W'(NPIXELS - 1));
   assign px_stray   = px_wr & ~cap_en & (state == ST_CAPTURE);
   assign px_cnt_upd = px_cnt + PX_W'(px_take);

   assign cap_start = ~abort & (state == ST_ARM) & (mode_s != MODE_STOP)
                    & vs_fall & (skip_cnt == '0);
   assign frame_end = ~abort & (state == ST_CAPTURE) & vs_rise;

`ifdef CAP_LINE_CHECK_EN
   localparam int unsigned LN_W = $clog2(NLINES + 2);

   logic            hr_rise, hr_fall_unused;
   logic [LN_W-1:0] line_cnt, line_cnt_upd;

   sync_edge_det #(.RST_VAL(1'b0)) u_href_det (
      .pclk   (pclk),
      .rst    (rst),
      .d      (href),
      .rise_c (hr_rise),
      .fall_c (hr_fall_unused)
   );

   // saturating so a runaway href cannot wrap back onto NLINES
   assign line_cnt_upd = (state == ST_CAPTURE && hr_rise && line_cnt != '1)
                       ? line_cnt + LN_W'(1) : line_cnt;
   assign line_bad     = (line_cnt_upd != LN_W'(NLINES));

   // line counter and sticky line error
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         line_cnt <= '0;
         line_err <= 1'b0;
      end else if (cap_start) begin
         line_cnt <= '0;
         line_err <= 1'b0;
      end else if (!abort && state == ST_CAPTURE) begin
         line_cnt <= line_cnt_upd;
         if (frame_end && line_bad) line_err <= 1'b1;
      end
   end
`else
   logic unused_href;
   assign unused_href = href ^ (NLINES == 0);
   assign line_bad    = 1'b0;
`endif

   // state and output registers
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         cap_en     <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         frame_cnt  <= '0;
         px_cnt     <= '0;
         skip_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         cap_en     <= cap_en_nxt;
         busy       <= busy_nxt;
         frame_done <= frame_done_nxt;
         frame_err  <= frame_err_nxt;
         frame_cnt  <= frame_cnt_nxt;
         px_cnt     <= px_cnt_nxt;
         skip_cnt   <= skip_cnt_nxt;
      end
   end

   // next state; abort overrides everything
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if ((mode_s == MODE_SINGLE && start) ||
                   mode_s == MODE_CONT || mode_s == MODE_DECIM)
                  state_nxt = ST_ARM;
            end
            ST_ARM: begin
               if (mode_s == MODE_STOP)
                  state_nxt = ST_IDLE;
               else if (vs_fall && skip_cnt == '0)
                  state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
               // mode is only looked at when the frame closes
               if (vs_rise)
                  state_nxt = (mode_s == MODE_CONT || mode_s == MODE_DECIM)
                            ? ST_ARM : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // next values of the registered outputs and counters
   always_comb begin
      cap_en_nxt     = cap_en;
      busy_nxt       = (state_nxt != ST_IDLE);
      frame_done_nxt = 1'b0;
      frame_err_nxt  = frame_err;
      frame_cnt_nxt  = frame_cnt;
      px_cnt_nxt     = px_cnt;
      skip_cnt_nxt   = skip_cnt;
      if (abort) begin
         cap_en_nxt   = 1'b0;
         skip_cnt_nxt = '0;
      end else begin
         case (state)
            ST_IDLE: skip_cnt_nxt = '0;
            ST_ARM: begin
               if (cap_start) begin
                  cap_en_nxt    = 1'b1;
                  px_cnt_nxt    = '0;
                  frame_err_nxt = 1'b0;
               end else if (mode_s != MODE_STOP && vs_fall) begin
                  skip_cnt_nxt = skip_cnt - SKIP_W'(1);
               end
            end
            ST_CAPTURE: begin
               px_cnt_nxt = px_cnt_upd;
               if (px_last)  cap_en_nxt    = 1'b0;
               if (px_stray) frame_err_nxt = 1'b1;
               if (frame_end) begin
                  cap_en_nxt     = 1'b0;
                  frame_done_nxt = 1'b1;
                  frame_cnt_nxt  = frame_cnt + CNT_W'(1);
                  if (px_cnt_upd != PX_W'(NPIXELS) || line_bad)
                     frame_err_nxt = 1'b1;
                  // DECIM reloads the drop count for the following frames
                  skip_cnt_nxt = (mode_s == MODE_DECIM) ? skip : '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Scoreboard bench for cam_capture_ctrl. Frames are scaled down (NPIX
// pixels) to keep the run short; pixel-count cases are relative to NPIX.
module tb_cam_capture_ctrl;
   import cam_pkg::*;

   localparam int NPIX   = 320;
   localparam int NLIN   = 120;
   localparam int CNT_W  = 8;
   localparam int SKIP_W = 4;

   logic              pclk  = 1'b0;
   logic              rst   = 1'b1;
   logic              vsync = 1'b1;
   logic              href  = 1'b0;
   logic              px_wr = 1'b0;
   logic [1:0]        mode  = 2'(MODE_STOP);
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [SKIP_W-1:0] skip  = '0;
   logic              cap_en, busy, frame_done, frame_err;
   logic [CNT_W-1:0]  frame_cnt;
`ifdef CAP_LINE_CHECK_EN
   logic              line_err;
`endif

   cam_capture_ctrl #(
      .NPIXELS (NPIX),
      .NLINES  (NLIN),
      .CNT_W   (CNT_W),
      .SKIP_W  (SKIP_W)
   ) dut (
      .pclk       (pclk),
      .rst        (rst),
      .vsync      (vsync),
      .href       (href),
      .px_wr      (px_wr),
      .mode       (mode),
      .start      (start),
      .abort      (abort),
      .skip       (skip),
      .cap_en     (cap_en),
      .busy       (busy),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .frame_cnt  (frame_cnt)
`ifdef CAP_LINE_CHECK_EN
      ,
      .line_err   (line_err)
`endif
   );

   always #5 pclk = ~pclk;

   typedef struct packed {
      logic [CNT_W-1:0] cnt;
      logic             err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_cnt = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // monitor: every frame_done is matched against the next expected frame
   always @(negedge pclk) begin
      if (rst && frame_done) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_frame_done: got pulse with frame_cnt %0d, expected no pulse",
                     frame_cnt);
         end else begin
            mon_e = exp_q.pop_front();
            check("done_frame_cnt", int'(frame_cnt), int'(mon_e.cnt));
            check("done_frame_err", int'(frame_err), int'(mon_e.err));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic pulse_start();
      @(negedge pclk) start = 1'b1;
      @(negedge pclk) start = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge pclk);
      rst   = 1'b0;
      vsync = 1'b1;
      href  = 1'b0;
      px_wr = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      mode  = 2'(MODE_STOP);
      skip  = '0;
      tick(2);
      rst     = 1'b1;
      exp_cnt = 0;
   endtask

   // one camera frame: vsync fall, nl href lines, npx px_wr pulses, vsync rise
   task automatic run_frame(input int npx, input int nl, input bit exp_cap,
                            input bit exp_err, input bit do_abort, input string name);
      int   cap_hi = 0;
      int   vs_bad = 0;
      exp_t e;
      @(negedge pclk) vsync = 1'b0;
      for (int l = 0; l < nl; l++) begin
         @(negedge pclk) href = 1'b1;
         @(negedge pclk) href = 1'b0;
      end
      for (int i = 0; i < npx; i++) begin
         @(negedge pclk);
         if (cap_en) cap_hi++;
         px_wr = 1'b1;
         @(negedge pclk) px_wr = 1'b0;
      end
      tick(2);
      @(negedge pclk);
      vsync = 1'b1;
      abort = do_abort;
      if (exp_cap && !do_abort) begin
         exp_cnt++;
         e.cnt = CNT_W'(exp_cnt);
         e.err = exp_err;
         exp_q.push_back(e);
      end
      @(negedge pclk) abort = 1'b0;
      if (do_abort) begin
         check({name, "_cap_en"},     int'(cap_en),     0);
         check({name, "_busy"},       int'(busy),       0);
         check({name, "_frame_done"}, int'(frame_done), 0);
         check({name, "_frame_cnt"},  int'(frame_cnt),  exp_cnt);
      end
      for (int k = 0; k < 4; k++) begin
         if (cap_en) vs_bad++;
         if (k < 3) @(negedge pclk);
      end
      check({name, "_cap_en_in_vblank"}, vs_bad, 0);
      check({name, "_gated_pixels"}, cap_hi, exp_cap ? ((npx < NPIX) ? npx : NPIX) : 0);
   endtask

   initial begin
      #1 rst = 1'b0;
      tick(2);
      check("reset_cap_en",     int'(cap_en),     0);
      check("reset_busy",       int'(busy),       0);
      check("reset_frame_done", int'(frame_done), 0);
      check("reset_frame_err",  int'(frame_err),  0);
      check("reset_frame_cnt",  int'(frame_cnt),  0);
      @(negedge pclk) rst = 1'b1;

      // start in STOP is ignored
      pulse_start();
      tick(1);
      check("stop_start_busy", int'(busy), 0);

      // SINGLE snapshot
      @(negedge pclk) mode = 2'(MODE_SINGLE);
      pulse_start();
      check("single_armed_busy", int'(busy), 1);
      run_frame(NPIX, NLIN, 1'b1, 1'b0, 1'b0, "single");
      check("single_busy_after", int'(busy),      0);
      check("single_frame_cnt",  int'(frame_cnt), 1);
      check("single_frame_err",  int'(frame_err), 0);
`ifdef CAP_LINE_CHECK_EN
      check("single_line_err",   int'(line_err),  0);
`endif
      // no re-arm without another start
      run_frame(NPIX, NLIN, 1'b0, 1'b0, 1'b0, "single_noarm");
      check("single_noarm_frame_cnt", int'(frame_cnt), 1);
      // abort beats a simultaneous start
      @(negedge pclk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge pclk);
      start = 1'b0;
      abort = 1'b0;
      tick(1);
      check("abort_start_busy", int'(busy), 0);

      // CONT over 3 frames
      do_reset();
      @(negedge pclk) mode = 2'(MODE_CONT);
      tick(2);
      check("cont_armed_busy", int'(busy), 1);
      repeat (3) run_frame(NPIX, NLIN, 1'b1, 1'b0, 1'b0, "cont");
      check("cont_frame_cnt", int'(frame_cnt), 3);
      @(negedge pclk) mode = 2'(MODE_STOP);
      tick(2);
      check("cont_stop_busy", int'(busy), 0);

      // DECIM skip=2: frames 1 and 4 captured
      do_reset();
      @(negedge pclk);
      mode = 2'(MODE_DECIM);
      skip = SKIP_W'(2);
      tick(2);
      for (int f = 1; f <= 6; f++)
         run_frame(NPIX, NLIN, (f == 1 || f == 4), 1'b0, 1'b0, "decim");
      check("decim_frame_cnt", int'(frame_cnt), 2);
      @(negedge pclk) mode = 2'(MODE_STOP);
      tick(2);

      // short, over-long, then a clean frame clearing the sticky error
      @(negedge pclk) mode = 2'(MODE_SINGLE);
      pulse_start();
      run_frame(NPIX - 200, NLIN, 1'b1, 1'b1, 1'b0, "short");
      tick(3);
      check("short_err_sticky", int'(frame_err), 1);
      pulse_start();
      run_frame(NPIX + 10, NLIN, 1'b1, 1'b1, 1'b0, "long");
      pulse_start();
      run_frame(NPIX, NLIN, 1'b1, 1'b0, 1'b0, "clean");
      check("clean_frame_cnt", int'(frame_cnt), 5);

      // abort together with vsync rise
      pulse_start();
      run_frame(NPIX, NLIN, 1'b1, 1'b0, 1'b1, "abort_rise");
      tick(3);

      // reset mid-frame
      pulse_start();
      @(negedge pclk) vsync = 1'b0;
      repeat (10) begin
         @(negedge pclk) px_wr = 1'b1;
         @(negedge pclk) px_wr = 1'b0;
      end
      check("midframe_cap_en", int'(cap_en), 1);
      #2 rst = 1'b0;
      #1;
      check("rst_async_cap_en",    int'(cap_en),    0);
      check("rst_async_busy",      int'(busy),      0);
      check("rst_async_frame_cnt", int'(frame_cnt), 0);
      check("rst_async_frame_err", int'(frame_err), 0);
      @(negedge pclk);
      rst   = 1'b1;
      vsync = 1'b1;
      mode  = 2'(MODE_STOP);
      exp_cnt = 0;
      tick(4);
      check("rst_after_busy", int'(busy), 0);

`ifdef CAP_LINE_CHECK_EN
      // one line short
      @(negedge pclk) mode = 2'(MODE_SINGLE);
      pulse_start();
      run_frame(NPIX, NLIN - 1, 1'b1, 1'b1, 1'b0, "short_lines");
      check("short_lines_line_err", int'(line_err), 1);
`endif

      tick(4);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1);
   end

endmodule
